// File: rtl/wrr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : wrr_arbiter_if
//  Description : Request/grant bundle between the requesters and wrr_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wrr_arbiter_if #(
    parameter int N  = 4,
    parameter int WW = 4
);
    localparam int IW = $clog2(N);

    logic [N-1:0]    req;
    logic [N-1:0]    lock;
    logic [N*WW-1:0] weight;
    logic            mode;
    logic [N-1:0]    grant;
    logic            grant_valid;
    logic [IW-1:0]   grant_id;

    // master = requester side, slave = arbiter side
    modport master (
        output req, lock, weight, mode,
        input  grant, grant_valid, grant_id
    );

    modport slave (
        input  req, lock, weight, mode,
        output grant, grant_valid, grant_id
    );
endinterface
`default_nettype wire

// File: rtl/wrr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wrr_arbiter
//  Description : Weighted round-robin arbiter with burst weights, grant lock
//                and a runtime fixed-priority mode. Registered one-hot grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module wrr_arbiter #(
    parameter int N  = 4,
    parameter int WW = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    wrr_arbiter_if.slave  bus
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] r_owner;
    logic [WW-1:0] r_credit;
    logic [IW-1:0] r_ptr;
    logic [N-1:0]  r_grant;
    logic          r_grant_valid;
    logic [IW-1:0] r_grant_id;

    logic [WW-1:0] w_weight [N];
    logic [N-1:0]  w_mask;
    logic [N-1:0]  w_masked_req;
    logic          w_hold;
    logic          w_any_req;
    logic [IW-1:0] w_winner;
    logic [N-1:0]  w_winner_onehot;

    function automatic logic [IW-1:0] f_lowest(input logic [N-1:0] v);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) idx = IW'(i);
        end
        return idx;
    endfunction

    // Mask keeps only the indices strictly above the last arbitration winner
    for (genvar g = 0; g < N; g++) begin : g_slice
        assign w_weight[g] = bus.weight[g*WW +: WW];
        assign w_mask[g]   = (g > int'(r_ptr));
    end

    assign w_masked_req = bus.req & w_mask;
    assign w_any_req    = |bus.req;
    assign w_hold       = r_grant_valid && bus.req[r_owner] &&
                          (bus.lock[r_owner] || (r_credit != '0));

    always_comb begin
        w_winner = f_lowest(bus.req);
        if (!bus.mode && (|w_masked_req)) begin
            w_winner = f_lowest(w_masked_req);
        end
        w_winner_onehot = {{(N-1){1'b0}}, 1'b1} << w_winner;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner       <= '0;
            r_credit      <= '0;
            r_ptr         <= IW'(N - 1);
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
        end else if (w_hold) begin
            // A locked hold freezes the credit; otherwise it is nonzero here
            if (!bus.lock[r_owner]) begin
                r_credit <= r_credit - 1'b1;
            end
        end else if (w_any_req) begin
            r_owner       <= w_winner;
            r_ptr         <= w_winner;
            r_credit      <= w_weight[w_winner];
            r_grant       <= w_winner_onehot;
            r_grant_valid <= 1'b1;
            r_grant_id    <= w_winner;
        end else begin
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
        end
    end

    assign bus.grant       = r_grant;
    assign bus.grant_valid = r_grant_valid;
    assign bus.grant_id    = r_grant_id;
endmodule
`default_nettype wire

// File: tb/tb_wrr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wrr_arbiter
//  Description : Directed scenarios plus randomized traffic for wrr_arbiter,
//                checked against a cycle-level behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wrr_arbiter;
    localparam int N  = 4;
    localparam int WW = 4;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    int         m_owner;
    int         m_credit;
    int         m_ptr;
    logic       m_valid;
    logic [N-1:0] m_grant;
    int         m_id;

    wrr_arbiter_if #(.N(N), .WW(WW)) intf ();

    wrr_arbiter #(.N(N), .WW(WW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_w(input int idx, input int val);
        intf.weight[idx*WW +: WW] = WW'(val);
    endtask

    function automatic void model_reset();
        m_owner  = 0;
        m_credit = 0;
        m_ptr    = N - 1;
        m_valid  = 1'b0;
        m_grant  = '0;
        m_id     = 0;
    endfunction

    // One clock edge of the arbiter, stated directly from the rules
    function automatic void model_edge();
        bit hold;
        int win;
        hold = m_valid && intf.req[m_owner] && (intf.lock[m_owner] || m_credit > 0);
        if (hold) begin
            if (!intf.lock[m_owner]) m_credit = m_credit - 1;
        end else if (intf.req != '0) begin
            win = -1;
            if (intf.mode) begin
                for (int i = 0; i < N; i++)
                    if (win < 0 && intf.req[i]) win = i;
            end else begin
                for (int k = 1; k <= N; k++)
                    if (win < 0 && intf.req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
            m_owner  = win;
            m_ptr    = win;
            m_credit = int'(intf.weight[win*WW +: WW]);
            m_valid  = 1'b1;
            m_grant  = N'(1) << win;
            m_id     = win;
        end else begin
            m_valid = 1'b0;
            m_grant = '0;
            m_id    = 0;
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("grant",       32'(intf.grant),       32'(m_grant));
        chk("grant_valid", 32'(intf.grant_valid), 32'(m_valid));
        chk("grant_id",    32'(intf.grant_id),    32'(m_id));
    endtask

    // Asserted between edges: outputs must clear before the next clk edge
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_grant",       32'(intf.grant),       32'(0));
        chk("rst_grant_valid", 32'(intf.grant_valid), 32'(0));
        chk("rst_grant_id",    32'(intf.grant_id),    32'(0));
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        intf.req    = '0;
        intf.lock   = '0;
        intf.weight = '0;
        intf.mode   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Plain rotation
        intf.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("rotation", 32'(intf.grant), 32'(4'b0001 << (k % 4)));
        end

        // Weighted burst: 3 cycles on 0, 1 cycle on 1
        do_reset();
        set_w(0, 2);
        set_w(1, 0);
        intf.req = 4'b0011;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("burst", 32'(intf.grant), ((k % 4) < 3) ? 32'(4'b0001) : 32'(4'b0010));
        end

        // Lock extension
        do_reset();
        intf.weight = '0;
        intf.req    = 4'b0101;
        intf.lock   = 4'b0001;
        repeat (4) cycle();
        intf.lock = 4'b0000;
        repeat (4) cycle();

        // Fixed priority, starvation, then mode change during a hold
        do_reset();
        intf.mode = 1'b1;
        intf.req  = 4'b1010;
        repeat (3) cycle();
        chk("fixed_prio", 32'(intf.grant), 32'(4'b0010));
        intf.req = 4'b1000;
        cycle();
        chk("starve_end", 32'(intf.grant), 32'(4'b1000));
        intf.req = 4'b1010;
        set_w(1, 3);
        cycle();
        intf.mode = 1'b0;
        repeat (6) cycle();
        set_w(1, 0);

        // Early release and wrap
        do_reset();
        set_w(2, 7);
        intf.req = 4'b0100;
        repeat (2) cycle();
        intf.req = 4'b0000;
        cycle();
        chk("release_valid", 32'(intf.grant_valid), 32'(0));
        intf.req = 4'b0101;
        cycle();
        chk("wrap", 32'(intf.grant), 32'(4'b0001));
        cycle();
        chk("wrap_next", 32'(intf.grant), 32'(4'b0100));

        // Reset mid-hold, then restart from ptr = N-1
        do_reset();
        set_w(1, 5);
        intf.req = 4'b0010;
        repeat (2) cycle();
        intf.req = 4'b1110;
        #2;
        do_reset();
        cycle();
        chk("post_reset", 32'(intf.grant), 32'(4'b0010));
        repeat (3) cycle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) intf.req = N'($urandom_range(0, (1 << N) - 1));
            intf.lock = '0;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 4) == 0) intf.lock[i] = 1'b1;
            if ($urandom_range(0, 5) == 0)
                set_w(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 4)));
            if ($urandom_range(0, 19) == 0) intf.mode = ~intf.mode;
            if ($urandom_range(0, 99) == 0) do_reset();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
